// File: rtl/pixel_stream_gen_pkg.sv
// Shared types for the test-image pixel source: scan states and pattern selectors.
package pixel_stream_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HBL    = 2'd2,
      VBL    = 2'd3
   } state_t;

   localparam logic [1:0] MODE_ROM  = 2'd0;
   localparam logic [1:0] MODE_GRAD = 2'd1;
   localparam logic [1:0] MODE_CHK  = 2'd2;
   localparam logic [1:0] MODE_ANIM = 2'd3;

endpackage

// File: rtl/pixel_stream_gen_pattern_rom.sv
// Stored test image, one word per pixel in raster order; purely combinational lookup.
module pattern_rom
   import pixel_stream_gen_pkg::*;
#(
   parameter int COLS  = 16,
   parameter int ROWS  = 16,
   parameter int PIX_W = 8
) (
   input  logic [$clog2(COLS*ROWS)-1:0] addr,
   output logic [PIX_W-1:0]             data
);

   // Image body as emitted by the template flow for the default test card.
   always_comb begin
      data = PIX_W'(int'(addr) * 37 + 11);
   end

endmodule

// File: rtl/pixel_stream_gen.sv
// Raster test-pattern source: one registered pixel per Valid&Ready transfer, 1-cycle start latency.
// Outputs hold while Valid&!Ready; line/frame blanking and start/stop are resolved at line/frame ends.
module pixel_stream_gen
   import pixel_stream_gen_pkg::*;
#(
   parameter int COLS   = 16,
   parameter int ROWS   = 16,
   parameter int PIX_W  = 8,
   parameter int HBLANK = 2,
   parameter int VBLANK = 4,
   parameter int CNT_W  = 8
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Enable,
   input  logic [1:0]       Mode,
   input  logic             Ready,
   output logic             Valid,
   output logic [PIX_W-1:0] Pixel,
   output logic             Frame,
   output logic             Line,
   output logic             LastPix,
   output logic [CNT_W-1:0] FrameCount
);

   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);
   localparam int AW   = $clog2(COLS*ROWS);
   localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
   localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

   state_t           state, state_n;
   logic [CW-1:0]    col, col_n;
   logic [RW-1:0]    row, row_n;
   logic [1:0]       mode_q, mode_n;
   logic [BW-1:0]    cnt, cnt_n;
   logic [CNT_W-1:0] fc_n;
   logic             valid_n, frame_n, line_n, last_n;
   logic             load, restart;
   logic [AW-1:0]    rom_addr;
   logic [PIX_W-1:0] rom_data, pat;

   // Next-state logic; row_n/col_n/mode_n/fc_n describe the pixel presented after the edge when load=1.
   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      mode_n  = mode_q;
      cnt_n   = cnt;
      fc_n    = FrameCount;
      valid_n = Valid;
      load    = 1'b0;
      restart = 1'b0;
      case (state)
         IDLE: begin
            valid_n = 1'b0;
            if (Enable) begin
               mode_n  = Mode;
               col_n   = '0;
               row_n   = '0;
               state_n = ACTIVE;
               load    = 1'b1;
            end
         end
         ACTIVE: begin
            if (Valid && Ready) begin
               if (col != CW'(COLS-1)) begin
                  col_n = col + CW'(1);
                  load  = 1'b1;
               end else if (row != RW'(ROWS-1)) begin
                  col_n = '0;
                  row_n = row + RW'(1);
                  if (HBLANK > 0) begin
                     state_n = HBL;
                     cnt_n   = '0;
                     valid_n = 1'b0;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  col_n = '0;
                  row_n = '0;
                  fc_n  = FrameCount + CNT_W'(1);
                  if (VBLANK > 0) begin
                     state_n = VBL;
                     cnt_n   = '0;
                     valid_n = 1'b0;
                  end else begin
                     restart = 1'b1;
                  end
               end
            end
         end
         HBL: begin
            if (int'(cnt) == HBLANK-1) begin
               state_n = ACTIVE;
               load    = 1'b1;
            end else begin
               cnt_n = cnt + BW'(1);
            end
         end
         VBL: begin
            if (int'(cnt) == VBLANK-1) restart = 1'b1;
            else                       cnt_n   = cnt + BW'(1);
         end
         default: state_n = IDLE;
      endcase

      // Frame boundary: Enable decides whether another frame follows.
      if (restart) begin
         if (Enable) begin
            mode_n  = Mode;
            state_n = ACTIVE;
            load    = 1'b1;
         end else begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      end
      if (load) valid_n = 1'b1;
   end

   always_comb begin
      frame_n = Frame;
      line_n  = Line;
      last_n  = LastPix;
      if (load) begin
         frame_n = (row_n == '0) && (col_n == '0);
         line_n  = (col_n == '0);
         last_n  = (row_n == RW'(ROWS-1)) && (col_n == CW'(COLS-1));
      end else if (!valid_n) begin
         frame_n = 1'b0;
         line_n  = 1'b0;
         last_n  = 1'b0;
      end
   end

   assign rom_addr = AW'(int'(row_n) * COLS + int'(col_n));

   pattern_rom #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .PIX_W (PIX_W)
   ) u_rom (
      .addr (rom_addr),
      .data (rom_data)
   );

   always_comb begin
      case (mode_n)
         MODE_ROM:  pat = rom_data;
         MODE_GRAD: pat = PIX_W'((int'(col_n) << PIX_W) / COLS);
         MODE_CHK:  pat = (row_n[0] ^ col_n[0]) ? '1 : '0;
         default:   pat = PIX_W'(int'(row_n) + int'(col_n) + int'(fc_n));
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         mode_q     <= MODE_ROM;
         cnt        <= '0;
         Valid      <= 1'b0;
         Pixel      <= '0;
         Frame      <= 1'b0;
         Line       <= 1'b0;
         LastPix    <= 1'b0;
         FrameCount <= '0;
      end else begin
         state      <= state_n;
         col        <= col_n;
         row        <= row_n;
         mode_q     <= mode_n;
         cnt        <= cnt_n;
         Valid      <= valid_n;
         Frame      <= frame_n;
         Line       <= line_n;
         LastPix    <= last_n;
         FrameCount <= fc_n;
         if (load) Pixel <= pat;
      end
   end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen: 4x3 frames on a blanking instance and a zero-blanking instance.
module tb_pixel_stream_gen;
   import pixel_stream_gen_pkg::*;

   typedef struct {
      logic [7:0] pix;
      logic       f;
      logic       l;
      logic       lp;
   } exp_t;

   logic       Clk = 1'b0;
   logic       nReset;
   logic       Enable, Ready;
   logic [1:0] Mode;
   logic       Valid, Frame, Line, LastPix;
   logic [7:0] Pixel, FrameCount;

   logic       enable_b;
   logic       ready_b = 1'b1;
   logic [1:0] mode_b;
   logic       valid_b, frame_b, line_b, lastpix_b;
   logic [7:0] pixel_b, fcount_b;

   int   checks = 0;
   int   errors = 0;
   int   nbeat = 0, cyc = 0, lowrun = 0, base = 0;
   int   nbeat_b = 0, cycb = 0, firstb = 0, lastb = 0;
   int   gapq[$];
   int   fsq[$];
   exp_t expq[$];
   exp_t qb[$];
   bit   prev_stall = 1'b0;
   exp_t held;

   pixel_stream_gen #(
      .COLS(4), .ROWS(3), .PIX_W(8), .HBLANK(2), .VBLANK(3), .CNT_W(8)
   ) u_dut (
      .Clk(Clk), .nReset(nReset), .Enable(Enable), .Mode(Mode), .Ready(Ready),
      .Valid(Valid), .Pixel(Pixel), .Frame(Frame), .Line(Line), .LastPix(LastPix),
      .FrameCount(FrameCount)
   );

   pixel_stream_gen #(
      .COLS(4), .ROWS(3), .PIX_W(8), .HBLANK(0), .VBLANK(0), .CNT_W(8)
   ) u_dut0 (
      .Clk(Clk), .nReset(nReset), .Enable(enable_b), .Mode(mode_b), .Ready(ready_b),
      .Valid(valid_b), .Pixel(pixel_b), .Frame(frame_b), .Line(line_b), .LastPix(lastpix_b),
      .FrameCount(fcount_b)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(int r, int c, int m, int fc);
      case (m)
         0:       return 8'((r*4 + c) * 37 + 11);
         1:       return 8'((c * 256) / 4);
         2:       return ((r ^ c) & 1) ? 8'hFF : 8'h00;
         default: return 8'(r + c + fc);
      endcase
   endfunction

   function automatic void push_frame(bit to_b, int m, int fc);
      exp_t e;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            e.pix = model(r, c, m, fc);
            e.f   = (r == 0 && c == 0);
            e.l   = (c == 0);
            e.lp  = (r == 2 && c == 3);
            if (to_b) qb.push_back(e);
            else      expq.push_back(e);
         end
      end
   endfunction

   function automatic int gap_at(int i);
      return (i < gapq.size()) ? gapq[i] : -1;
   endfunction

   // Scoreboard and handshake monitor for the blanking instance.
   always @(negedge Clk) begin
      exp_t e;
      if (!nReset) begin
         prev_stall = 1'b0;
         lowrun     = 0;
      end else begin
         cyc++;
         if (prev_stall) begin
            check("stall_valid", Valid, 1);
            check("stall_pix", Pixel, held.pix);
            check("stall_frame", Frame, held.f);
            check("stall_line", Line, held.l);
            check("stall_last", LastPix, held.lp);
         end
         if (Valid && Ready) begin
            nbeat++;
            if (Frame) fsq.push_back(cyc);
            if (expq.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               e = expq.pop_front();
               check("beat_pix", Pixel, e.pix);
               check("beat_frame", Frame, e.f);
               check("beat_line", Line, e.l);
               check("beat_last", LastPix, e.lp);
            end
         end
         prev_stall = Valid && !Ready;
         if (prev_stall) begin
            held.pix = Pixel; held.f = Frame; held.l = Line; held.lp = LastPix;
         end
         if (!Valid) lowrun++;
         else begin
            if (lowrun > 0) gapq.push_back(lowrun);
            lowrun = 0;
         end
      end
   end

   always @(negedge Clk) begin
      exp_t e;
      if (nReset) begin
         cycb++;
         if (valid_b && ready_b) begin
            nbeat_b++;
            if (nbeat_b == 1) firstb = cycb;
            lastb = cycb;
            if (qb.size() == 0) begin
               check("b_extra_beat", 1, 0);
            end else begin
               e = qb.pop_front();
               check("b_pix", pixel_b, e.pix);
               check("b_frame", frame_b, e.f);
               check("b_line", line_b, e.l);
               check("b_last", lastpix_b, e.lp);
            end
         end
      end
   end

   task automatic wait_beats(input int target, input string tag);
      for (int i = 0; i < 300; i++) begin
         if (nbeat >= target) break;
         @(posedge Clk); #1;
      end
      check(tag, nbeat >= target, 1);
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (expq.size() == 0) break;
         @(posedge Clk); #1;
      end
      check(tag, expq.size(), 0);
   endtask

   initial begin
      nReset = 1'b0; Enable = 1'b0; Mode = 2'd0; Ready = 1'b0;
      enable_b = 1'b0; mode_b = 2'd0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_valid", Valid, 0);
      check("rst_pixel", Pixel, 0);
      check("rst_frame", Frame, 0);
      check("rst_line", Line, 0);
      check("rst_lastpix", LastPix, 0);
      check("rst_framecount", FrameCount, 0);

      // Checkerboard frame; Enable drops while pixel (1,2) is presented.
      Enable = 1'b1; Mode = MODE_CHK; Ready = 1'b1;
      push_frame(0, 2, 0);
      @(negedge Clk); nReset = 1'b1;
      @(posedge Clk); #1;
      check("start_latency", Valid, 1);
      wait_beats(1, "p1_first");
      gapq.delete();
      wait_beats(6, "p1_pix12");
      Enable = 1'b0;
      wait_empty("p1_drain");
      repeat (10) @(posedge Clk);
      #1;
      check("p1_idle_valid", Valid, 0);
      check("p1_framecount", FrameCount, 1);
      check("p1_gap_count", gapq.size(), 2);
      check("p1_gap0", gap_at(0), 2);
      check("p1_gap1", gap_at(1), 2);

      // Two gradient frames back to back: row/frame blanking and frame period.
      fsq.delete();
      base = nbeat;
      Enable = 1'b1; Mode = MODE_GRAD;
      push_frame(0, 1, 1);
      push_frame(0, 1, 2);
      wait_beats(base + 1, "p2_first");
      gapq.delete();
      wait_beats(base + 13, "p2_second");
      Enable = 1'b0;
      wait_empty("p2_drain");
      repeat (8) @(posedge Clk);
      #1;
      check("p2_gap_count", gapq.size(), 5);
      check("p2_gap0", gap_at(0), 2);
      check("p2_gap1", gap_at(1), 2);
      check("p2_vblank", gap_at(2), 3);
      check("p2_gap3", gap_at(3), 2);
      check("p2_gap4", gap_at(4), 2);
      check("p2_starts", fsq.size(), 2);
      check("p2_period", (fsq.size() == 2) ? fsq[1] - fsq[0] : -1, 19);
      check("p2_framecount", FrameCount, 3);
      check("p2_idle_valid", Valid, 0);

      // ROM frame with pseudo-random Ready.
      base = nbeat;
      Enable = 1'b1; Mode = MODE_ROM;
      push_frame(0, 0, 3);
      for (int i = 0; i < 400 && expq.size() > 0; i++) begin
         @(posedge Clk); #1;
         Ready = 1'($urandom_range(0, 1));
         if (nbeat > base) Enable = 1'b0;
      end
      Ready = 1'b1;
      check("p3_drain", expq.size(), 0);
      repeat (6) @(posedge Clk);
      #1;
      check("p3_framecount", FrameCount, 4);

      // Reset while pixel (2,1) is presented, then restart from (0,0).
      base = nbeat;
      Enable = 1'b1; Mode = MODE_GRAD;
      push_frame(0, 1, 4);
      wait_beats(base + 9, "p4_pix21");
      nReset = 1'b0;
      #1;
      check("p4_rst_valid", Valid, 0);
      check("p4_rst_pixel", Pixel, 0);
      check("p4_rst_frame", Frame, 0);
      check("p4_rst_line", Line, 0);
      check("p4_rst_lastpix", LastPix, 0);
      check("p4_rst_framecount", FrameCount, 0);
      expq.delete();
      push_frame(0, 1, 0);
      @(negedge Clk); nReset = 1'b1;
      @(posedge Clk); #1;
      check("p4_restart_valid", Valid, 1);
      check("p4_restart_frame", Frame, 1);
      check("p4_restart_framecount", FrameCount, 0);
      Enable = 1'b0;
      wait_empty("p4_drain");
      repeat (6) @(posedge Clk);
      #1;
      check("p4_framecount", FrameCount, 1);

      // Zero-blanking instance: animated frames, Mode change takes effect at the next frame.
      push_frame(1, 3, 0);
      push_frame(1, 3, 1);
      push_frame(1, 3, 2);
      push_frame(1, 2, 3);
      enable_b = 1'b1; mode_b = MODE_ANIM;
      repeat (30) @(posedge Clk);
      #1 mode_b = MODE_CHK;
      repeat (12) @(posedge Clk);
      #1 enable_b = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (qb.size() == 0) break;
         @(posedge Clk); #1;
      end
      check("b_drain", qb.size(), 0);
      repeat (4) @(posedge Clk);
      #1;
      check("b_beats", nbeat_b, 48);
      check("b_back_to_back", lastb - firstb, 47);
      check("b_framecount", fcount_b, 4);
      check("b_idle_valid", valid_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
